store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of pending store entries (power of 2).
REQ-002 SHALL have port clock  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port storeEnable  in  1  store-RS issue strobe; one store per cycle.
REQ-005 SHALL have port robNum_in  in  6  ROB tag of the issued store.
REQ-006 SHALL have port data_in  in  32  store value.
REQ-007 SHALL have port addr_in  in  32  effective byte address.
REQ-008 SHALL have port subType  in  3  000 SB, 001 SH, 010 SW.
REQ-009 SHALL have port full  out  1  high when count==DEPTH.
REQ-010 SHALL have port readyValid / readyRob  out  1 / 6  pulse telling ROB the store is resolved.
REQ-011 SHALL have port commitValid / commitRob  in  1 / 6  ROB commit of a store tag.
REQ-012 SHALL have port flush  in  1  mispredict squash.
REQ-013 SHALL have port memReq / memAddr / memWData / memByteEn  out  1 / 32 / 32 / 4  data-memory write request.
REQ-014 SHALL have port memAck  in  1  memory accepts the held request this cycle.
REQ-015 SHALL have port alignErr / alignRob  out  1 / 6  misaligned-store pulse.

Function
REQ-016 SHALL hold a circular FIFO of DEPTH entries {rob, data, addr, subType, committed}, with head, tail and count registers.
REQ-017 SHALL, on an edge with storeEnable=1, full=0 and flush=0, write the entry at tail with committed=0, advance tail (mod DEPTH), and increment count.
REQ-018 SHALL ignore storeEnable while full=0 is false, including in a cycle where the head drains; upstream must gate on full.
REQ-019 SHALL raise readyValid for exactly the one cycle after an accepted enqueue, with readyRob equal to the enqueued tag.
REQ-020 SHALL, on commitValid, set committed on the single valid entry whose rob equals commitRob; a tag that matches no entry is ignored.
REQ-021 SHALL run a drain FSM with states IDLE, REQ and ACKD.
REQ-022 SHALL move from IDLE to REQ when the head entry is valid and committed; memReq is asserted starting the next cycle.
REQ-023 SHALL hold memReq, memAddr, memWData and memByteEn stable in REQ until memAck=1.
REQ-024 SHALL, on the memAck edge, pop head, decrement count, deassert memReq, and go to ACKD.
REQ-025 SHALL return from ACKD to IDLE after one cycle, so one store completes per 3 cycles at most.
REQ-026 SHALL drive memAddr = {addr[31:2], 2'b00}.
REQ-027 SHALL generate SB as memByteEn = 1<<addr[1:0], memWData = data[7:0] replicated to all 4 lanes.
REQ-028 SHALL generate SH as memByteEn = 0011 or 1100 by addr[1], memWData = data[15:0] replicated to both halves.
REQ-029 SHALL generate SW as memByteEn = 1111, memWData = data.
REQ-030 SHALL treat SH with addr[0]=1, SW with addr[1:0]!=0, or any other subType as misaligned.
REQ-031 SHALL, for a misaligned head, issue no memReq, pulse alignErr for one cycle with alignRob = rob, pop the entry, and go directly to ACKD.
REQ-032 SHALL, on flush, discard all uncommitted entries by setting tail = head + number of committed entries and updating count to match.
REQ-033 SHALL complete a REQ already in progress despite flush, because its head entry is committed.
REQ-034 SHALL give flush priority over a simultaneous storeEnable; the enqueue is dropped and readyValid is not pulsed.
REQ-035 SHALL apply a simultaneous commitValid before flush, so the entry just committed survives the flush.
REQ-036 SHALL allow simultaneous enqueue, commit and drain in one cycle, each taking effect.

Reset
REQ-037 SHALL, while reset=0, clear head, tail, count and all committed bits, force the FSM to IDLE, and drive all outputs to 0 (full=0).
REQ-038 SHALL abandon an in-flight request on reset mid-REQ: memReq drops asynchronously and no pop occurs.

Verification
REQ-039 SHALL cover: SW rob=5 data=0xDEADBEEF addr=0x100, commit 5, memAck after 2 cycles -> readyValid/readyRob=5 one cycle after issue; memAddr=0x100, memByteEn=1111 held until ack; count returns to 0.
REQ-040 SHALL cover: SB data=0x000000AB addr=0x203, SH data=0x1234 addr=0x206 -> memByteEn 1000 then 1100; memWData 0xABABABAB then 0x12341234.
REQ-041 SHALL cover: four stores issued and none committed, fifth storeEnable -> full=1, fifth dropped, no readyValid; commit first tag plus memAck -> full=0 after the pop.
REQ-042 SHALL cover: tags 1,2,3 enqueued, commitRob=1 in the same cycle as flush -> only tag 1 remains (count=1) and it drains; tags 2,3 never reach memory.
REQ-043 SHALL cover: SW addr=0x102 committed -> alignErr pulse with alignRob equal to the tag, memReq never asserted, entry popped.
REQ-044 SHALL cover: reset driven low while in REQ -> memReq=0 immediately; after release count=0, full=0, FSM in IDLE.

Source files
------------

// File: rtl/store_buffer_if.sv
// Store buffer bus: issue side from the store RS, commit side from the ROB,
// and the data-memory write port.
interface store_buffer_if;
    logic        storeEnable;
    logic [5:0]  robNum_in;
    logic [31:0] data_in;
    logic [31:0] addr_in;
    logic [2:0]  subType;
    logic        full;
    logic        readyValid;
    logic [5:0]  readyRob;
    logic        commitValid;
    logic [5:0]  commitRob;
    logic        flush;
    logic        memReq;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [3:0]  memByteEn;
    logic        memAck;
    logic        alignErr;
    logic [5:0]  alignRob;

    modport master (
        output storeEnable, robNum_in, data_in, addr_in, subType,
        output commitValid, commitRob, flush, memAck,
        input  full, readyValid, readyRob, memReq, memAddr, memWData,
        input  memByteEn, alignErr, alignRob
    );

    modport slave (
        input  storeEnable, robNum_in, data_in, addr_in, subType,
        input  commitValid, commitRob, flush, memAck,
        output full, readyValid, readyRob, memReq, memAddr, memWData,
        output memByteEn, alignErr, alignRob
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: holds issued stores until ROB commit, then drains them
// in order to data memory, one at a time.
//
// state | meaning
// IDLE  | waiting for a committed head entry
// REQ   | write request held on the memory port until memAck
// ACKD  | one-cycle gap after a pop (ack or misaligned discard)
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    store_buffer_if.slave sb
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, ACKD} state_t;

    logic [5:0]       rob_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      addr_q [DEPTH];
    logic [2:0]       sub_q  [DEPTH];
    logic [DEPTH-1:0] cmt_q, cmt_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d, cnt_pop, ncmt;

    state_t      state_q;
    logic        mem_req_q, align_err_q, ready_valid_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic [5:0]  align_rob_q, ready_rob_q;

    logic        enq, pop, head_ready, h_mis;
    logic [3:0]  h_be;
    logic [31:0] h_wd;

    // True when slot idx lies inside the window of c entries starting at h.
    function automatic logic in_win(input int idx, input logic [PW-1:0] h,
                                    input logic [CW-1:0] c);
        logic [PW-1:0] off;
        off = PW'(idx) - h;
        return {1'b0, off} < c;
    endfunction

    assign sb.full       = (count_q == CW'(DEPTH));
    assign sb.readyValid = ready_valid_q;
    assign sb.readyRob   = ready_rob_q;
    assign sb.memReq     = mem_req_q;
    assign sb.memAddr    = mem_addr_q;
    assign sb.memWData   = mem_wdata_q;
    assign sb.memByteEn  = mem_be_q;
    assign sb.alignErr   = align_err_q;
    assign sb.alignRob   = align_rob_q;

    assign enq        = sb.storeEnable && !sb.full && !sb.flush;
    assign head_ready = (count_q != '0) && cmt_q[head_q];
    assign pop        = ((state_q == IDLE) && head_ready && h_mis) ||
                        ((state_q == REQ) && sb.memAck);

    // Byte-lane steering and alignment check for the head entry.
    always_comb begin
        h_be  = 4'b0000;
        h_wd  = 32'h0;
        h_mis = 1'b0;
        case (sub_q[head_q])
            3'b000: begin
                h_be = 4'b0001 << addr_q[head_q][1:0];
                h_wd = {4{data_q[head_q][7:0]}};
            end
            3'b001: begin
                h_mis = addr_q[head_q][0];
                h_be  = addr_q[head_q][1] ? 4'b1100 : 4'b0011;
                h_wd  = {2{data_q[head_q][15:0]}};
            end
            3'b010: begin
                h_mis = (addr_q[head_q][1:0] != 2'b00);
                h_be  = 4'b1111;
                h_wd  = data_q[head_q];
            end
            default: h_mis = 1'b1;
        endcase
    end

    // Pointer/count/commit next state; commit lands before flush truncates.
    always_comb begin
        cmt_d = cmt_q;
        if (sb.commitValid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (in_win(i, head_q, count_q) && rob_q[i] == sb.commitRob)
                    cmt_d[i] = 1'b1;
            end
        end
        head_d  = head_q + PW'(pop);
        cnt_pop = count_q - CW'(pop);
        ncmt    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (in_win(i, head_d, cnt_pop) && cmt_d[i])
                ncmt = ncmt + CW'(1);
        end
        if (sb.flush) begin
            tail_d  = head_d + ncmt[PW-1:0];
            count_d = ncmt;
        end else begin
            tail_d  = tail_q + PW'(enq);
            count_d = cnt_pop + CW'(enq);
            if (enq)
                cmt_d[tail_q] = 1'b0;
        end
    end

    // Queue pointers, commit flags and the issue acknowledgement pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            cmt_q         <= '0;
            ready_valid_q <= 1'b0;
            ready_rob_q   <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            cmt_q         <= cmt_d;
            ready_valid_q <= enq;
            if (enq)
                ready_rob_q <= sb.robNum_in;
        end
    end

    // Entry payload storage; validity is tracked by head/count only.
    always_ff @(posedge clock) begin
        if (enq) begin
            rob_q[tail_q]  <= sb.robNum_in;
            data_q[tail_q] <= sb.data_in;
            addr_q[tail_q] <= sb.addr_in;
            sub_q[tail_q]  <= sb.subType;
        end
    end

    // Drain FSM with registered memory-port and alignment-error outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            align_err_q <= 1'b0;
            align_rob_q <= '0;
        end else begin
            align_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (head_ready) begin
                        if (h_mis) begin
                            align_err_q <= 1'b1;
                            align_rob_q <= rob_q[head_q];
                            state_q     <= ACKD;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {addr_q[head_q][31:2], 2'b00};
                            mem_wdata_q <= h_wd;
                            mem_be_q    <= h_be;
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (sb.memAck) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ACKD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: issue/commit/drain, byte lanes, full,
// flush with same-cycle commit, misalignment and mid-request reset.
module tb_store_buffer;
    logic clock;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    store_buffer_if sb ();

    store_buffer #(.DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic issue(input logic [5:0] rob, input logic [31:0] data,
                         input logic [31:0] addr, input logic [2:0] sub);
        sb.storeEnable = 1'b1;
        sb.robNum_in   = rob;
        sb.data_in     = data;
        sb.addr_in     = addr;
        sb.subType     = sub;
        step();
        sb.storeEnable = 1'b0;
    endtask

    task automatic commit(input logic [5:0] rob);
        sb.commitValid = 1'b1;
        sb.commitRob   = rob;
        step();
        sb.commitValid = 1'b0;
    endtask

    task automatic ack();
        sb.memAck = 1'b1;
        step();
        sb.memAck = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int i;
        i = 0;
        while (sb.memReq !== 1'b1 && i < 20) begin
            step();
            i++;
        end
        chk(tag, sb.memReq, 1);
    endtask

    // Misaligned store: committed, alignErr pulses two edges after commit.
    task automatic misaligned(input string tag, input logic [5:0] rob,
                              input logic [31:0] addr, input logic [2:0] sub);
        issue(rob, 32'h1111_2222, addr, sub);
        commit(rob);
        chk({tag, "_noreq0"}, sb.memReq, 0);
        step();
        chk({tag, "_err"}, sb.alignErr, 1);
        chk({tag, "_rob"}, sb.alignRob, 32'(rob));
        chk({tag, "_noreq"}, sb.memReq, 0);
        chk({tag, "_cnt"}, dut.count_q, 0);
        step();
        chk({tag, "_errclr"}, sb.alignErr, 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        sb.storeEnable = 1'b0;
        sb.robNum_in   = '0;
        sb.data_in     = '0;
        sb.addr_in     = '0;
        sb.subType     = '0;
        sb.commitValid = 1'b0;
        sb.commitRob   = '0;
        sb.flush       = 1'b0;
        sb.memAck      = 1'b0;
        step();
        step();
        chk("rst_full", sb.full, 0);
        chk("rst_memreq", sb.memReq, 0);
        chk("rst_ready", sb.readyValid, 0);
        chk("rst_alignerr", sb.alignErr, 0);
        chk("rst_count", dut.count_q, 0);
        reset = 1'b1;
        step();

        // SW rob 5, commit, ack after two cycles of request
        issue(6'd5, 32'hDEAD_BEEF, 32'h100, 3'b010);
        chk("sw_ready", sb.readyValid, 1);
        chk("sw_readyrob", sb.readyRob, 5);
        chk("sw_count1", dut.count_q, 1);
        commit(6'd5);
        chk("sw_ready_pulse", sb.readyValid, 0);
        chk("sw_noreq_yet", sb.memReq, 0);
        step();
        chk("sw_req", sb.memReq, 1);
        chk("sw_addr", sb.memAddr, 32'h100);
        chk("sw_be", sb.memByteEn, 4'b1111);
        chk("sw_wd", sb.memWData, 32'hDEAD_BEEF);
        step();
        chk("sw_req_hold", sb.memReq, 1);
        chk("sw_addr_hold", sb.memAddr, 32'h100);
        chk("sw_be_hold", sb.memByteEn, 4'b1111);
        ack();
        chk("sw_req_drop", sb.memReq, 0);
        chk("sw_count0", dut.count_q, 0);
        step();

        // SB at 0x203 then SH at 0x206, back to back
        issue(6'd10, 32'h0000_00AB, 32'h203, 3'b000);
        issue(6'd11, 32'h0000_1234, 32'h206, 3'b001);
        chk("lane_readyrob", sb.readyRob, 11);
        commit(6'd10);
        commit(6'd11);
        wait_req("sb_req");
        chk("sb_addr", sb.memAddr, 32'h200);
        chk("sb_be", sb.memByteEn, 4'b1000);
        chk("sb_wd", sb.memWData, 32'hABAB_ABAB);
        ack();
        chk("sb_count", dut.count_q, 1);
        wait_req("sh_req");
        chk("sh_addr", sb.memAddr, 32'h204);
        chk("sh_be", sb.memByteEn, 4'b1100);
        chk("sh_wd", sb.memWData, 32'h1234_1234);
        ack();
        chk("sh_count", dut.count_q, 0);
        step();

        // fill to DEPTH, fifth store is dropped
        for (int i = 0; i < 4; i++)
            issue(6'(20 + i), 32'(i), 32'h300 + 32'(4 * i), 3'b010);
        chk("full_set", sb.full, 1);
        chk("full_count", dut.count_q, 4);
        issue(6'd24, 32'h0, 32'h310, 3'b010);
        chk("full_drop_ready", sb.readyValid, 0);
        chk("full_drop_count", dut.count_q, 4);
        commit(6'd20);
        wait_req("full_req");
        chk("full_req_addr", sb.memAddr, 32'h300);
        ack();
        chk("full_clear", sb.full, 0);
        chk("full_pop_count", dut.count_q, 3);
        sb.flush = 1'b1;
        step();
        sb.flush = 1'b0;
        chk("full_flush_count", dut.count_q, 0);
        step();

        // flush with a same-cycle commit of the oldest tag
        issue(6'd1, 32'hA1, 32'h400, 3'b010);
        issue(6'd2, 32'hA2, 32'h404, 3'b010);
        issue(6'd3, 32'hA3, 32'h408, 3'b010);
        sb.commitValid = 1'b1;
        sb.commitRob   = 6'd1;
        sb.flush       = 1'b1;
        sb.storeEnable = 1'b1;
        sb.robNum_in   = 6'd4;
        sb.addr_in     = 32'h40C;
        step();
        sb.commitValid = 1'b0;
        sb.flush       = 1'b0;
        sb.storeEnable = 1'b0;
        chk("flush_count", dut.count_q, 1);
        chk("flush_noready", sb.readyValid, 0);
        wait_req("flush_req");
        chk("flush_addr", sb.memAddr, 32'h400);
        chk("flush_wd", sb.memWData, 32'hA1);
        ack();
        chk("flush_count0", dut.count_q, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_noreq", sb.memReq, 0);
        end

        // misaligned SW, SH and an undefined subType
        misaligned("mis_sw", 6'd33, 32'h102, 3'b010);
        misaligned("mis_sh", 6'd34, 32'h101, 3'b001);
        misaligned("mis_sub", 6'd35, 32'h000, 3'b011);

        // reset asserted while a request is held
        issue(6'd40, 32'h55, 32'h500, 3'b010);
        commit(6'd40);
        wait_req("rst_req");
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_memreq", sb.memReq, 0);
        chk("rst_async_count", dut.count_q, 0);
        chk("rst_async_full", sb.full, 0);
        step();
        reset = 1'b1;
        step();
        chk("rst_state_idle", 32'(dut.state_q), 0);
        chk("rst_after_count", dut.count_q, 0);
        step();
        step();
        chk("rst_no_replay", sb.memReq, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
